// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate-extension unit with valid/ready flow
// control and flush, placed between the decode and execute stages.
//
// Parameters:
//   IMM_W  - raw immediate width (8 <= IMM_W <= DATA_W-2)
//   DATA_W - extended result width
//   STAGES - register stages, 1 or 2
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   flush               - kills every in-flight entry next cycle
//   in_valid/in_ready   - upstream handshake for in_imm/in_op
//   in_imm, in_op       - raw immediate and extension mode
//   out_valid/out_ready - downstream handshake for the result
//   out_data            - extended value
//   out_illegal         - result came from a reserved mode (6 or 7)
module imm_ext_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_illegal
);

  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_ZEXT  = 3'd1,
    OP_SEXT  = 3'd2,
    OP_UPPER = 3'd3,
    OP_BRANCH = 3'd4,
    OP_BYTE  = 3'd5
  } ext_op_e;

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ext_data;
  logic              ext_illegal;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ill_q;
  logic [DATA_W-1:0] d_q [STAGES];

  logic adv_last;
  logic adv0;
  logic take;
  logic move_last;

  // Combinational extension of the incoming immediate.
  always_comb begin
    sext        = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    ext_data    = '0;
    ext_illegal = 1'b0;
    case (in_op)
      OP_ZERO:   ext_data = '0;
      OP_ZEXT:   ext_data = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      OP_SEXT:   ext_data = sext;
      OP_UPPER:  ext_data = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      // Shift drops the two top sign copies; low bits fill with zero.
      OP_BRANCH: ext_data = sext << 2;
      OP_BYTE:   ext_data = {{(DATA_W-8){in_imm[7]}}, in_imm[7:0]};
      default: begin
        ext_data    = '0;
        ext_illegal = 1'b1;
      end
    endcase
  end

  // Stage advance terms: a stage may load when it is empty or its entry
  // leaves. Written without a vector self-loop so each term is acyclic.
  always_comb begin
    adv_last = !v_q[LAST] || out_ready;
    if (STAGES == 1) begin
      adv0 = adv_last;
    end else begin
      adv0 = !v_q[0] || adv_last;
    end
    in_ready  = !reset && !flush && adv0;
    take      = in_valid && in_ready;
    move_last = (STAGES == 2) && !flush && v_q[0] && adv_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      ill_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      if (flush) begin
        v_q <= '0;
      end else begin
        if (adv0) begin
          v_q[0] <= take;
        end
        if ((STAGES == 2) && adv_last) begin
          v_q[LAST] <= v_q[0];
        end
      end
      if (take) begin
        d_q[0]   <= ext_data;
        ill_q[0] <= ext_illegal;
      end
      if (move_last) begin
        d_q[LAST]   <= d_q[0];
        ill_q[LAST] <= ill_q[0];
      end
    end
  end

  assign out_valid   = v_q[LAST];
  assign out_data    = d_q[LAST];
  assign out_illegal = ill_q[LAST];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: three instances (default 1-stage, 2-stage,
// and a 12-bit/24-bit 1-stage variant), table-driven extension vectors,
// then hand-written stall, flush and reset sequences.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // u1: defaults (IMM_W=16, DATA_W=32, STAGES=1)
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_illegal;
  logic [15:0] a_in_imm = '0;
  logic [2:0]  a_in_op = '0;
  logic [31:0] a_out_data;

  // u2: STAGES=2
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_illegal;
  logic [15:0] b_in_imm = '0;
  logic [2:0]  b_in_op = '0;
  logic [31:0] b_out_data;

  // u3: IMM_W=12, DATA_W=24
  logic        c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1, c_out_illegal;
  logic [11:0] c_in_imm = '0;
  logic [2:0]  c_in_op = '0;
  logic [23:0] c_out_data;

  imm_ext_pipe u1 (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_imm(a_in_imm), .in_op(a_in_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_illegal(a_out_illegal));

  imm_ext_pipe #(.STAGES(2)) u2 (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_imm(b_in_imm), .in_op(b_in_op), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_illegal(b_out_illegal));

  imm_ext_pipe #(.IMM_W(12), .DATA_W(24)) u3 (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_imm(c_in_imm), .in_op(c_in_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_illegal(c_out_illegal));

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  op;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t tab_a [14];
  vec_t tab_c [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset u1 while it is presenting a result; expect a clean restart.
  task automatic reset_midstream(input logic [15:0] imm, input logic [2:0] op,
                                 input logic [31:0] exp_d, input logic exp_i);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_imm = imm; a_in_op = op;
    cyc();
    reset = 1'b1;
    a_in_imm = 16'h1234; a_in_op = 3'd1;
    @(negedge clk);
    chk("rst_pre_valid", 32'(a_out_valid), 32'd1);
    chk("rst_pre_data", a_out_data, exp_d);
    chk("rst_pre_ill", 32'(a_out_illegal), 32'(exp_i));
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    cyc();
    reset = 1'b0;
    a_in_valid = 1'b1; a_in_imm = 16'h00FF; a_in_op = 3'd5;
    @(negedge clk);
    chk("rst_post_valid", 32'(a_out_valid), 32'd0);
    chk("rst_post_data", a_out_data, 32'd0);
    chk("rst_post_ill", 32'(a_out_illegal), 32'd0);
    chk("rst_post_in_ready", 32'(a_in_ready), 32'd1);
    cyc();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_valid", 32'(a_out_valid), 32'd1);
    chk("rst_first_data", a_out_data, 32'hFFFF_FFFF);
    cyc();
  endtask

  // Watchdog: the bench has no open-ended waits, but guard anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tab_a[0]  = '{16'h8001, 3'd0, 32'h0000_0000, 1'b0};
    tab_a[1]  = '{16'h8001, 3'd1, 32'h0000_8001, 1'b0};
    tab_a[2]  = '{16'h8001, 3'd2, 32'hFFFF_8001, 1'b0};
    tab_a[3]  = '{16'h8001, 3'd3, 32'h8001_0000, 1'b0};
    tab_a[4]  = '{16'h8001, 3'd4, 32'hFFFE_0004, 1'b0};
    tab_a[5]  = '{16'h8001, 3'd5, 32'h0000_0001, 1'b0};
    tab_a[6]  = '{16'hFFFF, 3'd6, 32'h0000_0000, 1'b1};
    tab_a[7]  = '{16'hFFFF, 3'd7, 32'h0000_0000, 1'b1};
    tab_a[8]  = '{16'h7FFF, 3'd2, 32'h0000_7FFF, 1'b0};
    tab_a[9]  = '{16'h7FFF, 3'd4, 32'h0001_FFFC, 1'b0};
    tab_a[10] = '{16'h1280, 3'd5, 32'hFFFF_FF80, 1'b0};
    tab_a[11] = '{16'hFF7F, 3'd5, 32'h0000_007F, 1'b0};
    tab_a[12] = '{16'h1234, 3'd3, 32'h1234_0000, 1'b0};
    tab_a[13] = '{16'hFFFF, 3'd1, 32'h0000_FFFF, 1'b0};

    tab_c[0] = '{16'h0800, 3'd2, 32'h00FF_F800, 1'b0};
    tab_c[1] = '{16'h0800, 3'd3, 32'h0080_0000, 1'b0};
    tab_c[2] = '{16'h0800, 3'd4, 32'h00FF_E000, 1'b0};

    // Reset state
    cyc();
    @(negedge clk);
    chk("reset_a_valid", 32'(a_out_valid), 32'd0);
    chk("reset_a_data", a_out_data, 32'd0);
    chk("reset_a_ill", 32'(a_out_illegal), 32'd0);
    chk("reset_a_in_ready", 32'(a_in_ready), 32'd0);
    chk("reset_b_valid", 32'(b_out_valid), 32'd0);
    chk("reset_b_data", b_out_data, 32'd0);
    chk("reset_b_in_ready", 32'(b_in_ready), 32'd0);
    chk("reset_c_valid", 32'(c_out_valid), 32'd0);
    chk("reset_c_data", 32'(c_out_data), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Back-to-back table on u1: each result one cycle after acceptance
    for (int i = 0; i <= 14; i++) begin
      if (i < 14) begin
        a_in_valid = 1'b1; a_in_imm = tab_a[i].imm; a_in_op = tab_a[i].op;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 14) chk($sformatf("a_in_ready[%0d]", i), 32'(a_in_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("a_valid[%0d]", i-1), 32'(a_out_valid), 32'd1);
        chk($sformatf("a_data[%0d]", i-1), a_out_data, tab_a[i-1].exp_data);
        chk($sformatf("a_ill[%0d]", i-1), 32'(a_out_illegal), 32'(tab_a[i-1].exp_ill));
      end
      cyc();
    end
    @(negedge clk);
    chk("a_drained", 32'(a_out_valid), 32'd0);
    cyc();

    // Narrow-width instance
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        c_in_valid = 1'b1; c_in_imm = tab_c[i].imm[11:0]; c_in_op = tab_c[i].op;
      end else begin
        c_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("c_valid[%0d]", i-1), 32'(c_out_valid), 32'd1);
        chk($sformatf("c_data[%0d]", i-1), 32'(c_out_data), tab_c[i-1].exp_data);
      end
      cyc();
    end

    // STAGES=2 stall: stream 1..4 (zero-extend), out_ready low from cycle 2
    b_in_op = 3'd1;
    b_in_valid = 1'b1; b_in_imm = 16'd1; b_out_ready = 1'b1;
    @(negedge clk);
    chk("st_c0_in_ready", 32'(b_in_ready), 32'd1);
    cyc();
    b_in_imm = 16'd2;
    @(negedge clk);
    chk("st_c1_valid", 32'(b_out_valid), 32'd0);
    chk("st_c1_in_ready", 32'(b_in_ready), 32'd1);
    cyc();
    b_in_imm = 16'd3; b_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("st_hold_valid[%0d]", k), 32'(b_out_valid), 32'd1);
      chk($sformatf("st_hold_data[%0d]", k), b_out_data, 32'd1);
      chk($sformatf("st_hold_in_ready[%0d]", k), 32'(b_in_ready), 32'd0);
      cyc();
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("st_rel_in_ready", 32'(b_in_ready), 32'd1);
    chk("st_rel_data1", b_out_data, 32'd1);
    cyc();
    b_in_imm = 16'd4;
    @(negedge clk);
    chk("st_data2", b_out_data, 32'd2);
    chk("st_data2_valid", 32'(b_out_valid), 32'd1);
    cyc();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("st_data3", b_out_data, 32'd3);
    chk("st_data3_valid", 32'(b_out_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("st_data4", b_out_data, 32'd4);
    chk("st_data4_valid", 32'(b_out_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("st_empty", 32'(b_out_valid), 32'd0);
    cyc();

    // STAGES=2 flush of a full, stalled pipe
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_imm = 16'd5;
    cyc();
    b_in_imm = 16'd6;
    cyc();
    b_in_imm = 16'd7;
    @(negedge clk);
    chk("fl_full_in_ready", 32'(b_in_ready), 32'd0);
    chk("fl_full_valid", 32'(b_out_valid), 32'd1);
    chk("fl_full_data", b_out_data, 32'd5);
    cyc();
    b_flush = 1'b1; b_in_imm = 16'd8;
    @(negedge clk);
    chk("fl_in_ready_during", 32'(b_in_ready), 32'd0);
    cyc();
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("fl_after_valid[%0d]", k), 32'(b_out_valid), 32'd0);
      chk($sformatf("fl_after_in_ready[%0d]", k), 32'(b_in_ready), 32'd1);
      cyc();
    end
    b_in_valid = 1'b1; b_in_imm = 16'd9;
    cyc();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("fl_resume_lat1", 32'(b_out_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("fl_resume_valid", 32'(b_out_valid), 32'd1);
    chk("fl_resume_data", b_out_data, 32'd9);
    cyc();

    // Reset while a result is presented (data and illegal flavours)
    reset_midstream(16'h8001, 3'd2, 32'hFFFF_8001, 1'b0);
    reset_midstream(16'hFFFF, 3'd6, 32'h0000_0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
